// File: rtl/flap_game_ctrl.sv
// flap_game_ctrl
// Game-state controller for the Flappy Bird datapath. Sequences play through
// IDLE -> PLAY -> OVER. While in PLAY it owns the bird row (gravity and flap
// moves), detects pipe and ground collisions, keeps the score, and emits the
// gravity/scroll tick that paces the pipe scroller and the LED display.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   flap      in   single-cycle flap pulse from the debounced key block
//   pipe_col  in   [ROWS] pipe occupancy of the bird's column, 1 = wall
//   pipe_pass in   single-cycle pulse when a pipe column leaves the bird's column
//   bird_row  out  [ROW_W] current bird row, 0 = top, ROWS-1 = ground
//   state     out  [2] 00 IDLE, 01 PLAY, 10 OVER
//   score     out  [8] pipes passed, saturating at 255
//   tick      out  single-cycle pulse every GRAV_DIV clocks while in PLAY
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a flap; bird parked at START_ROW, score cleared
// PLAY  | gravity, flaps, collision checks and scoring are live
// OVER  | frozen for display until the next flap returns to IDLE
module flap_game_ctrl #(
  parameter int ROWS      = 16,
  parameter int ROW_W     = 4,
  parameter int START_ROW = 8,
  parameter int FLAP_ROWS = 2,
  parameter int GRAV_DIV  = 12_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flap,
  input  logic [ROWS-1:0]  pipe_col,
  input  logic             pipe_pass,
  output logic [ROW_W-1:0] bird_row,
  output logic [1:0]       state,
  output logic [7:0]       score,
  output logic             tick
);

  localparam int CNT_W = (GRAV_DIV > 2) ? $clog2(GRAV_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GRAV_DIV - 1);
  localparam logic [ROW_W-1:0] START_R  = ROW_W'(START_ROW);
  localparam logic [ROW_W-1:0] FLAP_R   = ROW_W'(FLAP_ROWS);
  localparam logic [ROW_W-1:0] GROUND_R = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             cnt_wrap;
  logic             hit;
  logic             score_inc;

  assign cnt_wrap  = (cnt == CNT_MAX);
  // Collision looks at the registered row, i.e. where the bird is shown now.
  assign hit       = pipe_col[bird_row];
  assign score_inc = pipe_pass && (score != 8'hFF);
  assign state     = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= S_IDLE;
      bird_row <= START_R;
      score    <= 8'd0;
      tick     <= 1'b0;
      cnt      <= '0;
    end else begin
      tick <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (flap) begin
            st  <= S_PLAY;
            cnt <= '0;
          end
        end
        S_PLAY: begin
          if (hit) begin
            // Everything freezes; pipe_pass in this cycle is dropped.
            st <= S_OVER;
          end else begin
            cnt  <= cnt_wrap ? '0 : cnt + 1'b1;
            tick <= cnt_wrap;
            // A flap overrides the gravity step of the same cycle.
            if (flap) begin
              bird_row <= (bird_row < FLAP_R) ? '0 : bird_row - FLAP_R;
            end else if (cnt_wrap) begin
              if (bird_row == GROUND_R) st <= S_OVER;
              else bird_row <= bird_row + 1'b1;
            end
            if (score_inc) score <= score + 8'd1;
          end
        end
        S_OVER: begin
          if (flap) begin
            st       <= S_IDLE;
            bird_row <= START_R;
            score    <= 8'd0;
            cnt      <= '0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flap_game_ctrl.sv
module tb_flap_game_ctrl;

  localparam int G = 4;

  logic        clk;
  logic        reset;
  logic        flap;
  logic [15:0] pipe_col;
  logic        pipe_pass;
  logic [3:0]  bird_row;
  logic [1:0]  state;
  logic [7:0]  score;
  logic        tick;

  int n_vec = 0;
  int n_err = 0;

  flap_game_ctrl #(
    .ROWS(16), .ROW_W(4), .START_ROW(8), .FLAP_ROWS(2), .GRAV_DIV(G)
  ) dut (
    .clk(clk), .reset(reset), .flap(flap), .pipe_col(pipe_col),
    .pipe_pass(pipe_pass), .bird_row(bird_row), .state(state),
    .score(score), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: game phase as 0/1/2, row/score as plain integers,
  // tick derived from the number of live PLAY cycles since entering play.
  int m_state = 0, m_row = 8, m_score = 0, m_tick = 0, m_edges = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; m_row = 8; m_score = 0; m_tick = 0; m_edges = 0;
      m_valid = 1;
    end else if (m_state == 0) begin
      m_tick = 0;
      if (flap) begin m_state = 1; m_edges = 0; end
    end else if (m_state == 1) begin
      if (pipe_col[m_row]) begin
        m_state = 2; m_tick = 0;
      end else begin
        m_edges = m_edges + 1;
        m_tick  = (m_edges % G == 0) ? 1 : 0;
        if (flap) m_row = (m_row - 2 < 0) ? 0 : m_row - 2;
        else if (m_tick == 1) begin
          if (m_row == 15) m_state = 2;
          else m_row = m_row + 1;
        end
        if (pipe_pass) m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
      end
    end else begin
      m_tick = 0;
      if (flap) begin m_state = 0; m_row = 8; m_score = 0; end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_vec++;
      if (int'(state) != m_state || int'(bird_row) != m_row ||
          int'(score) != m_score || int'(tick) != m_tick) begin
        n_err++;
        $display("FAIL model t=%0t got st=%0d row=%0d sc=%0d tk=%0d exp st=%0d row=%0d sc=%0d tk=%0d",
                 $time, state, bird_row, score, tick, m_state, m_row, m_score, m_tick);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic f, input logic [15:0] pc, input logic pp, input logic r);
    flap = f; pipe_col = pc; pipe_pass = pp; reset = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flap = 1'b0; pipe_col = 16'h0; pipe_pass = 1'b0;
    @(negedge clk);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("rst_state", int'(state), 0);
    chk("rst_row", int'(bird_row), 8);
    chk("rst_score", int'(score), 0);
    chk("rst_tick", int'(tick), 0);
    idle(20);
    chk("idle_state", int'(state), 0);
    chk("idle_row", int'(bird_row), 8);

    // Start play and fall to the ground.
    step(1'b1, 16'h0, 1'b0, 1'b0);
    chk("start_state", int'(state), 1);
    chk("start_row", int'(bird_row), 8);
    for (int k = 1; k <= 7; k++) begin
      for (int j = 0; j < 3; j++) begin
        idle(1);
        chk("fall_tick_low", int'(tick), 0);
      end
      idle(1);
      chk("fall_tick_high", int'(tick), 1);
      chk("fall_row", int'(bird_row), 8 + k);
    end
    idle(4);
    chk("ground_state", int'(state), 2);
    chk("ground_row", int'(bird_row), 15);
    idle(5);
    chk("over_hold_state", int'(state), 2);
    chk("over_hold_row", int'(bird_row), 15);
    chk("over_tick", int'(tick), 0);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    chk("restart_state", int'(state), 0);
    chk("restart_row", int'(bird_row), 8);
    chk("restart_score", int'(score), 0);

    // Top saturation.
    step(1'b1, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    chk("sat_row2", int'(bird_row), 2);
    idle(1);
    chk("sat_row3", int'(bird_row), 3);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    chk("sat_row1", int'(bird_row), 1);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    chk("sat_row0", int'(bird_row), 0);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    chk("sat_row0b", int'(bird_row), 0);

    // Flap in the tick cycle from row 6.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    chk("ft_row6", int'(bird_row), 6);
    idle(2);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    chk("ft_row4", int'(bird_row), 4);
    chk("ft_tick", int'(tick), 1);

    // Pipe collision with simultaneous pipe_pass.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0100, 1'b1, 1'b0);
    chk("coll_state", int'(state), 2);
    chk("coll_score", int'(score), 0);
    chk("coll_tick", int'(tick), 0);
    idle(6);
    chk("coll_tick_frozen", int'(tick), 0);
    chk("coll_row_frozen", int'(bird_row), 8);

    // Scoring, then reset mid-play at row 11, score 5.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      if (i == 2) chk("score3", int'(score), 3);
    end
    idle(7);
    chk("mid_row", int'(bird_row), 11);
    chk("mid_score", int'(score), 5);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_row", int'(bird_row), 8);
    chk("mid_rst_score", int'(score), 0);
    chk("mid_rst_tick", int'(tick), 0);

    // Score saturation: 300 pulses with periodic flaps to stay airborne.
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step((i % 8) == 7, 16'h0, 1'b1, 1'b0);
    chk("sat_score", int'(score), 255);
    chk("sat_state", int'(state), 1);

    // Randomized play checked against the model every cycle.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      logic        f, pp, r;
      logic [15:0] pc;
      f  = ($urandom_range(0, 5) == 0);
      pp = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 499) == 0);
      pc = ($urandom_range(0, 24) == 0) ? 16'($urandom) : 16'h0;
      step(f, pc, pp, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
